// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, issue-stage FSM states and command record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous command FIFO, power-of-two depth, wrapping pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     din,
    input  logic                     pop,
    output cmd_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so natural overflow gives the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module      : alu_issue_stage
// Description : Queues ALU commands, issues them to an external datapath and
//               returns registered responses. Optional macro
//               ALU_DIV_ZERO_TRAP_EN forces div-by-zero results to 0 with rsp_dz.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    output logic [7:0]               au_a,
    output logic [7:0]               au_b,
    output logic [1:0]               au_op,
    input  logic [15:0]              au_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_result,
    output logic [1:0]               rsp_op,
    output logic                     rsp_zero,
    output logic                     rsp_dz,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    state_e      r_state;
    state_e      w_state_nxt;
    cmd_t        w_cmd_in;
    cmd_t        w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_dz;
    logic [15:0] w_result;

    logic [7:0]  r_au_a;
    logic [7:0]  r_au_b;
    logic [1:0]  r_au_op;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_result;
    logic [1:0]  r_rsp_op;
    logic        r_rsp_zero;
    logic        r_rsp_dz;

    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;
    assign w_cmd_in  = '{op: cmd_op, a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_cmd_in),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    // Back-to-back: next head goes straight to ISSUE on the handshake edge.
                    w_pop       = ~w_empty;
                    w_state_nxt = w_empty ? IDLE : ISSUE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ALU_DIV_ZERO_TRAP_EN
    assign w_dz     = (r_au_op == OP_DIV) && (r_au_b == 8'h00);
    assign w_result = w_dz ? 16'h0000 : au_result;
`else
    assign w_dz     = 1'b0;
    assign w_result = au_result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_au_a       <= '0;
            r_au_b       <= '0;
            r_au_op      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_op     <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_dz     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_au_a  <= w_head.a;
                r_au_b  <= w_head.b;
                r_au_op <= w_head.op;
            end
            if (r_state == ISSUE) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= w_result;
                r_rsp_op     <= r_au_op;
                r_rsp_zero   <= (w_result == 16'h0000);
                r_rsp_dz     <= w_dz;
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign au_a       = r_au_a;
    assign au_b       = r_au_b;
    assign au_op      = r_au_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_op     = r_rsp_op;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_dz     = r_rsp_dz;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench with an external datapath model and a
//               response scoreboard; honours ALU_DIV_ZERO_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [7:0]  au_a;
    logic [7:0]  au_b;
    logic [1:0]  au_op;
    logic [15:0] au_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_op;
    logic        rsp_zero;
    logic        rsp_dz;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct packed {
        logic [15:0] res;
        logic [1:0]  op;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_op      (au_op),
        .au_result  (au_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_zero   (rsp_zero),
        .rsp_dz     (rsp_dz),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Downstream signed datapath; div-by-zero returns all ones.
    function automatic logic [15:0] dp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] x;
        logic signed [15:0] y;
        x = {{8{a[7]}}, a};
        y = {{8{b[7]}}, b};
        case (op)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return x * y;
            default: return (b == 8'h00) ? 16'hFFFF : x / y;
        endcase
    endfunction

    assign au_result = dp(au_op, au_a, au_b);

    function automatic exp_t expect_rsp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.op  = op;
        e.res = dp(op, a, b);
        e.dz  = 1'b0;
`ifdef ALU_DIV_ZERO_TRAP_EN
        if (op == 2'b11 && b == 8'h00) begin
            e.res = 16'h0000;
            e.dz  = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: samples on the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            int   diff;
            exp_t e;
            chk("cmd_ready", cmd_ready, (fifo_count != DEPTH));
            diff = exp_q.size() - int'(fifo_count);
            chk("occupancy", (diff == 0 || diff == 1), 1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_op", rsp_op, e.op);
                    chk("rsp_zero", rsp_zero, (e.res == 16'h0000));
                    chk("rsp_dz", rsp_dz, e.dz);
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(expect_rsp(cmd_op, cmd_a, cmd_b));
        end
    end

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a  = a;
        cmd_b  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        bit seen;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_au", {au_op, au_a, au_b}, 0);
        chk("rst_rsp", {rsp_result, rsp_op, rsp_zero, rsp_dz}, 0);

        // Single add latency: accept at N, pop at N+1, response after N+2
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_a  = 8'd5;
        cmd_b  = 8'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("lat_n_valid", rsp_valid, 0);
        chk("lat_n_count", fifo_count, 1);
        @(posedge clk);
        #1;
        chk("lat_n1_valid", rsp_valid, 0);
        chk("lat_n1_count", fifo_count, 0);
        chk("lat_n1_au", {au_op, au_a, au_b}, {2'b00, 8'd5, 8'd3});
        @(posedge clk);
        #1;
        chk("lat_n2_valid", rsp_valid, 1);
        chk("lat_n2_result", rsp_result, 16'h0008);
        chk("lat_n2_zero", rsp_zero, 0);
        drain();

        // Fill: one in the stage, four queued
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'($urandom), 8'($urandom), 8'($urandom));
        @(posedge clk);
        #1;
        chk("fill_count", fifo_count, 4);
        chk("fill_cmd_ready", cmd_ready, 0);
        chk("fill_rsp_valid", rsp_valid, 1);
        drain();

        // Backpressure on a mul: -3 * 7 = -21
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        push(2'b10, 8'hFD, 8'd7);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 16'hFFEB);
            chk("bp_op", rsp_op, 2'b10);
            @(negedge clk);
        end
        drain();

        // Divide by zero and a zero-result add
        @(posedge clk);
        #1;
        push(2'b11, 8'd7, 8'd0);
        push(2'b00, 8'd5, 8'hFB);
        drain();

        // Simultaneous push and pop keeps the count
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        push(2'b01, 8'd9, 8'd4);
        push(2'b10, 8'd2, 8'd6);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("pp_seen", seen, 1);
        chk("pp_count_before", fifo_count, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_a  = 8'd1;
        cmd_b  = 8'd1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("pp_count_after", fifo_count, 1);
        chk("pp_issue_gap", rsp_valid, 0);
        drain();

        // Streaming throughput: one response every two cycles
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        hs = 0;
        for (int i = 0; i < 40; i++) begin
            cmd_op = 2'($urandom);
            cmd_a  = 8'($urandom);
            cmd_b  = 8'($urandom);
            @(negedge clk);
            if (i >= 20 && rsp_valid) hs++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("stream_rate", hs, 10);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_a     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        // Reset mid-stream: one in RESP, three queued
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'($urandom), 8'($urandom), 8'($urandom));
        @(posedge clk);
        #1;
        chk("mid_count", fifo_count, 3);
        chk("mid_valid", rsp_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", rsp_valid, 0);
        end
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
